// File: rtl/led_sequencer_fsm.sv
// led_sequencer_fsm
//   RGB LED sequencer driven by two push-buttons. GREEN idle, BLUE blinking
//   countdown, RED alarm, and a PAUSED (steady cyan) mode. Leaving RED needs
//   sw2 held for HOLD_CYCLES consecutive cycles. Buttons are synchronised and
//   rising-edge detected inside the block.
//
//   Ports
//     clk            system clock
//     rst_n          asynchronous active-low reset, clears every flop
//     sw1, sw2       raw asynchronous active-high buttons
//     red/green/blue registered LED drives, one cycle behind state_o
//     state_o        current state (GREEN=00, BLUE=01, RED=10, PAUSED=11)
//     blink_count_o  number of completed blink intervals in the countdown
module led_sequencer_fsm #(
    parameter int BLINK_INTERVAL  = 6000000,
    parameter int MAX_BLINK_COUNT = 20,
    parameter int HOLD_CYCLES     = 24000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 sw1,
    input  logic                                 sw2,
    output logic                                 red,
    output logic                                 green,
    output logic                                 blue,
    output logic [1:0]                           state_o,
    output logic [$clog2(MAX_BLINK_COUNT+1)-1:0] blink_count_o
);

    localparam int CNT_W  = (BLINK_INTERVAL > 1) ? $clog2(BLINK_INTERVAL) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BC_W   = $clog2(MAX_BLINK_COUNT+1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_INTERVAL - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BC_W-1:0]   BC_DONE   = BC_W'(MAX_BLINK_COUNT);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_BLUE   = 2'b01,
        ST_RED    = 2'b10,
        ST_PAUSED = 2'b11
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         count, count_nxt;
    logic [BC_W-1:0]          blink_count, blink_count_nxt;
    logic [HOLD_W-1:0]        hold_cnt, hold_cnt_nxt;
    logic                     red_nxt, green_nxt, blue_nxt;

    logic [SYNC_STAGES-1:0]   sw1_sync, sw2_sync;
    logic                     sw1_s_d, sw2_s_d;
    logic                     sw1_s, sw2_s;
    logic                     sw1_rise, sw2_rise;
    logic                     blink_done;

    // Synchronised levels come from the last stage of each chain; the extra
    // delayed copy gives a single-cycle pulse per press, however long it is held.
    assign sw1_s      = sw1_sync[SYNC_STAGES-1];
    assign sw2_s      = sw2_sync[SYNC_STAGES-1];
    assign sw1_rise   = sw1_s & ~sw1_s_d;
    assign sw2_rise   = sw2_s & ~sw2_s_d;
    assign blink_done = (blink_count == BC_DONE);

    assign state_o       = state;
    assign blink_count_o = blink_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw1_sync    <= '0;
            sw2_sync    <= '0;
            sw1_s_d     <= 1'b0;
            sw2_s_d     <= 1'b0;
            state       <= ST_GREEN;
            count       <= '0;
            blink_count <= '0;
            hold_cnt    <= '0;
            red         <= 1'b0;
            green       <= 1'b0;
            blue        <= 1'b0;
        end else begin
            sw1_sync    <= {sw1_sync[SYNC_STAGES-2:0], sw1};
            sw2_sync    <= {sw2_sync[SYNC_STAGES-2:0], sw2};
            sw1_s_d     <= sw1_s;
            sw2_s_d     <= sw2_s;
            state       <= state_nxt;
            count       <= count_nxt;
            blink_count <= blink_count_nxt;
            hold_cnt    <= hold_cnt_nxt;
            red         <= red_nxt;
            green       <= green_nxt;
            blue        <= blue_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        blink_count_nxt = blink_count;
        hold_cnt_nxt    = '0;
        red_nxt         = 1'b0;
        green_nxt       = 1'b0;
        blue_nxt        = 1'b0;

        case (state)
            ST_GREEN: begin
                green_nxt       = 1'b1;
                count_nxt       = '0;
                blink_count_nxt = '0;
                if (sw1_rise) state_nxt = ST_BLUE;
            end
            ST_BLUE: begin
                // LED is lit during even intervals so it starts on at entry.
                blue_nxt = ~blink_count[0];
                if (count == CNT_LAST) begin
                    count_nxt = '0;
                    // Saturate so a tiny interval cannot overrun the done value.
                    if (!blink_done) blink_count_nxt = blink_count + 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
                // The alarm outranks any button activity in the same cycle.
                if (blink_done)    state_nxt = ST_RED;
                else if (sw2_rise) state_nxt = ST_GREEN;
                else if (sw1_rise) state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                green_nxt = 1'b1;
                blue_nxt  = 1'b1;
                if (sw2_rise)      state_nxt = ST_GREEN;
                else if (sw1_rise) state_nxt = ST_BLUE;
            end
            ST_RED: begin
                red_nxt         = 1'b1;
                count_nxt       = '0;
                blink_count_nxt = '0;
                // Only a continuous hold counts; any release restarts the count.
                if (sw2_s) begin
                    if (hold_cnt == HOLD_LAST) state_nxt = ST_GREEN;
                    else                       hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_led_sequencer_fsm.sv
module tb_led_sequencer_fsm;

    localparam int BI = 4;
    localparam int MB = 3;
    localparam int HC = 8;
    localparam int SS = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw1   = 1'b0;
    logic       sw2   = 1'b0;
    logic       red, green, blue;
    logic [1:0] state_o;
    logic [1:0] blink_count_o;

    int n_cmp = 0;
    int n_err = 0;

    led_sequencer_fsm #(
        .BLINK_INTERVAL (BI),
        .MAX_BLINK_COUNT(MB),
        .HOLD_CYCLES    (HC),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw1          (sw1),
        .sw2          (sw2),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .state_o      (state_o),
        .blink_count_o(blink_count_o)
    );

    always #5 clk = ~clk;

    // Behavioural reference: pin history stands in for the synchroniser, the
    // state is a plain integer (0 green, 1 blue, 2 red, 3 paused) and the
    // countdown is kept as "intervals elapsed" plus a modulo cycle counter.
    int   m_state = 0, m_cnt = 0, m_bc = 0, m_hold = 0;
    logic m_red = 1'b0, m_green = 1'b0, m_blue = 1'b0;
    logic h1 [0:SS];
    logic h2 [0:SS];

    initial begin
        for (int i = 0; i <= SS; i++) begin h1[i] = 1'b0; h2[i] = 1'b0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = 0; m_cnt = 0; m_bc = 0; m_hold = 0;
                m_red = 1'b0; m_green = 1'b0; m_blue = 1'b0;
                for (int i = 0; i <= SS; i++) begin h1[i] = 1'b0; h2[i] = 1'b0; end
            end else begin
                int   ns;
                logic r1, r2, s2, done;
                r1   = h1[SS-1] && !h1[SS];
                r2   = h2[SS-1] && !h2[SS];
                s2   = h2[SS-1];
                done = (m_bc == MB);
                m_red   = (m_state == 2);
                m_green = (m_state == 0) || (m_state == 3);
                m_blue  = (m_state == 3) || (m_state == 1 && (m_bc % 2) == 0);
                ns = m_state;
                case (m_state)
                    0: if (r1) ns = 1;
                    1: if (done) ns = 2; else if (r2) ns = 0; else if (r1) ns = 3;
                    3: if (r2) ns = 0; else if (r1) ns = 1;
                    2: if (s2 && m_hold == HC-1) ns = 0;
                    default: ns = 0;
                endcase
                if (m_state == 2 && s2 && m_hold < HC-1) m_hold = m_hold + 1;
                else m_hold = 0;
                if (m_state == 0 || m_state == 2) begin
                    m_cnt = 0; m_bc = 0;
                end else if (m_state == 1) begin
                    m_cnt = (m_cnt + 1) % BI;
                    if (m_cnt == 0 && m_bc < MB) m_bc = m_bc + 1;
                end
                m_state = ns;
                for (int i = SS; i > 0; i--) begin h1[i] = h1[i-1]; h2[i] = h2[i-1]; end
                h1[0] = sw1; h2[0] = sw2;
            end
        end
    end

    logic [6:0] dut_vec, m_vec;
    logic [1:0] m_state2, m_bc2;
    assign m_state2 = m_state[1:0];
    assign m_bc2    = m_bc[1:0];
    assign dut_vec  = {red, green, blue, state_o, blink_count_o};
    assign m_vec    = {m_red, m_green, m_blue, m_state2, m_bc2};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sw1 = 1'b0; sw2 = 1'b0;
        tick(1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (state_o == s) ok = 1'b1;
        end
    endtask

    task automatic press_sw1();
        sw1 = 1'b1; tick(1); sw1 = 1'b0;
    endtask

    task automatic test_reset();
        sw1 = 1'b0; sw2 = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 7'b0) begin
            n_err++; $display("FAIL reset_assert: got %b expected %b", dut_vec, 7'b0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        n_cmp++;
        if ({red, green, blue, state_o, blink_count_o} !== 7'b010_00_00) begin
            n_err++; $display("FAIL reset_release: got %b expected %b", dut_vec, 7'b010_00_00);
        end
        tick(5);
        n_cmp++;
        if (dut_vec !== m_vec) begin
            n_err++; $display("FAIL reset_idle: got %b expected %b", dut_vec, m_vec);
        end
    endtask

    task automatic test_blink_to_red();
        int lat, nblue, max_bc, toggles;
        logic prev_blue;
        do_reset();
        sw1 = 1'b1;
        lat = -1;
        for (int c = 0; c < 10 && lat < 0; c++) begin
            tick(1);
            if (c == 0) sw1 = 1'b0;
            if (state_o == 2'b01) lat = c;
        end
        n_cmp++;
        if (lat !== SS) begin
            n_err++; $display("FAIL press_latency: got %0d expected %0d", lat, SS);
        end
        n_cmp++;
        if ({red, green, blue} !== 3'b010) begin
            n_err++; $display("FAIL led_lag: got %b expected %b", {red, green, blue}, 3'b010);
        end
        tick(1);
        n_cmp++;
        if ({red, green, blue} !== 3'b001) begin
            n_err++; $display("FAIL blue_on: got %b expected %b", {red, green, blue}, 3'b001);
        end
        nblue = 2; max_bc = 0; toggles = 0; prev_blue = blue;
        for (int c = 0; c < 100 && state_o == 2'b01; c++) begin
            if (int'(blink_count_o) > max_bc) max_bc = int'(blink_count_o);
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL blink_model c=%0d: got %b expected %b", c, dut_vec, m_vec);
            end
            tick(1);
            if (state_o == 2'b01) nblue++;
            if (blue !== prev_blue) toggles++;
            prev_blue = blue;
        end
        n_cmp++;
        if (max_bc !== MB) begin
            n_err++; $display("FAIL max_blink_count: got %0d expected %0d", max_bc, MB);
        end
        n_cmp++;
        if (nblue !== MB*BI+1) begin
            n_err++; $display("FAIL blue_duration: got %0d expected %0d", nblue, MB*BI+1);
        end
        n_cmp++;
        if (toggles !== MB) begin
            n_err++; $display("FAIL blue_toggles: got %0d expected %0d", toggles, MB);
        end
        n_cmp++;
        if ({state_o, red} !== 3'b10_0) begin
            n_err++; $display("FAIL red_entry: got %b expected %b", {state_o, red}, 3'b100);
        end
        tick(1);
        n_cmp++;
        if ({red, green, blue} !== 3'b100) begin
            n_err++; $display("FAIL red_led: got %b expected %b", {red, green, blue}, 3'b100);
        end
    endtask

    task automatic test_pause();
        bit ok;
        do_reset();
        press_sw1();
        wait_state(2'b01, 10, ok);
        for (int i = 0; i < 20 && blink_count_o != 2'd1; i++) tick(1);
        press_sw1();
        wait_state(2'b11, 10, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL pause_entry: got state %b expected %b", state_o, 2'b11);
        end
        tick(1);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({state_o, red, green, blue, blink_count_o} !== 7'b11_011_01) begin
                n_err++;
                $display("FAIL paused_frozen i=%0d: got %b expected %b", i,
                         {state_o, red, green, blue, blink_count_o}, 7'b11_011_01);
            end
            tick(1);
        end
        press_sw1();
        wait_state(2'b01, 10, ok);
        n_cmp++;
        if (!ok || blink_count_o !== 2'd1) begin
            n_err++; $display("FAIL resume: got state %b count %0d expected 01 count 1", state_o, blink_count_o);
        end
        for (int c = 0; c < 40 && state_o != 2'b10; c++) begin
            tick(1);
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL resume_model c=%0d: got %b expected %b", c, dut_vec, m_vec);
            end
        end
        n_cmp++;
        if (state_o !== 2'b10) begin
            n_err++; $display("FAIL resume_to_red: got %b expected %b", state_o, 2'b10);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        press_sw1();
        wait_state(2'b01, 10, ok);
        tick(5);
        sw1 = 1'b1; sw2 = 1'b1;
        tick(1);
        sw1 = 1'b0; sw2 = 1'b0;
        for (int i = 0; i < 10 && state_o == 2'b01; i++) tick(1);
        n_cmp++;
        if (state_o !== 2'b00) begin
            n_err++; $display("FAIL both_press: got %b expected %b", state_o, 2'b00);
        end
        tick(2);
        n_cmp++;
        if ({red, green, blue, blink_count_o} !== 5'b010_00) begin
            n_err++; $display("FAIL both_cleared: got %b expected %b", {red, green, blue, blink_count_o}, 5'b01000);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int lat;
        do_reset();
        press_sw1();
        wait_state(2'b10, 40, ok);
        tick(2);
        press_sw1();
        tick(4);
        n_cmp++;
        if (state_o !== 2'b10) begin
            n_err++; $display("FAIL red_ignores_sw1: got %b expected %b", state_o, 2'b10);
        end
        sw2 = 1'b1; tick(HC-1); sw2 = 1'b0;
        tick(6);
        n_cmp++;
        if ({state_o, red} !== 3'b10_1) begin
            n_err++; $display("FAIL short_hold: got %b expected %b", {state_o, red}, 3'b101);
        end
        sw2 = 1'b1;
        lat = -1;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            tick(1);
            if (state_o == 2'b00) lat = c;
        end
        n_cmp++;
        if (lat !== SS-1+HC) begin
            n_err++; $display("FAIL long_hold: got %0d expected %0d", lat, SS-1+HC);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if ({state_o, red, green, blue} !== 5'b00_010) begin
                n_err++; $display("FAIL held_after_green i=%0d: got %b expected %b", i,
                                  {state_o, red, green, blue}, 5'b00010);
            end
        end
        sw2 = 1'b0;
        tick(4);
        n_cmp++;
        if (state_o !== 2'b00) begin
            n_err++; $display("FAIL release_after_green: got %b expected %b", state_o, 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        press_sw1();
        wait_state(2'b01, 10, ok);
        for (int i = 0; i < 20 && blink_count_o != 2'd2; i++) tick(1);
        n_cmp++;
        if (blink_count_o !== 2'd2) begin
            n_err++; $display("FAIL mid_blink_reach: got %0d expected 2", blink_count_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 7'b0) begin
            n_err++; $display("FAIL async_reset: got %b expected %b", dut_vec, 7'b0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        n_cmp++;
        if (dut_vec !== 7'b010_00_00) begin
            n_err++; $display("FAIL reset_recover: got %b expected %b", dut_vec, 7'b0100000);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) sw1 = ~sw1;
            if ($urandom_range(15) == 0) sw2 = ~sw2;
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(599) == 0) rst_n = 1'b0;
            tick(1);
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_err++; $display("FAIL random c=%0d: got %b expected %b", c, dut_vec, m_vec);
            end
        end
        rst_n = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_blink_to_red();
        test_pause();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
